// File: rtl/sorter.sv
// Weight sorter: classifies the item on the scale into one of six weight
// groups and counts each item once, when it leaves the scale.
module sorter (
    input  logic [11:0] in,
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  grp1,
    output logic [7:0]  grp2,
    output logic [7:0]  grp3,
    output logic [7:0]  grp4,
    output logic [7:0]  grp5,
    output logic [7:0]  grp6,
    output logic [2:0]  currgrp
);

    localparam int unsigned WEIGHT_W   = 12;
    localparam int unsigned COUNT_W    = 8;
    localparam int unsigned GROUP_W    = 3;
    localparam int unsigned NUM_GROUPS = 6;

    // Inclusive upper bounds of groups 1..5; anything above is group 6.
    localparam logic [WEIGHT_W-1:0] MAX_G1 = WEIGHT_W'(250);
    localparam logic [WEIGHT_W-1:0] MAX_G2 = WEIGHT_W'(500);
    localparam logic [WEIGHT_W-1:0] MAX_G3 = WEIGHT_W'(750);
    localparam logic [WEIGHT_W-1:0] MAX_G4 = WEIGHT_W'(1500);
    localparam logic [WEIGHT_W-1:0] MAX_G5 = WEIGHT_W'(2000);

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    logic [GROUP_W-1:0]                   cls_c;
    logic                                 leave_c;
    logic [NUM_GROUPS-1:0][COUNT_W-1:0]   count;

    // Weight classification of the current scale reading.
    always_comb begin
        cls_c = GROUP_W'(0);
        if (in == WEIGHT_W'(0)) begin
            cls_c = GROUP_W'(0);
        end else if (in <= MAX_G1) begin
            cls_c = GROUP_W'(1);
        end else if (in <= MAX_G2) begin
            cls_c = GROUP_W'(2);
        end else if (in <= MAX_G3) begin
            cls_c = GROUP_W'(3);
        end else if (in <= MAX_G4) begin
            cls_c = GROUP_W'(4);
        end else if (in <= MAX_G5) begin
            cls_c = GROUP_W'(5);
        end else begin
            cls_c = GROUP_W'(6);
        end
    end

    // The current item leaves when the class moves away from a nonzero group;
    // changes within the same class are the same item settling.
    always_comb begin
        leave_c = (currgrp != GROUP_W'(0)) && (cls_c != currgrp);
    end

    // Group of the item currently on the scale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            currgrp <= GROUP_W'(0);
        end else begin
            currgrp <= cls_c;
        end
    end

    // Saturating per-group counters; only the departing group advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (leave_c) begin
            for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
                if ((currgrp == GROUP_W'(g + 1)) && (count[g] != COUNT_MAX)) begin
                    count[g] <= count[g] + COUNT_W'(1);
                end
            end
        end
    end

    assign grp1 = count[0];
    assign grp2 = count[1];
    assign grp3 = count[2];
    assign grp4 = count[3];
    assign grp5 = count[4];
    assign grp6 = count[5];

endmodule

// File: tb/tb_sorter.sv
// Directed self-checking bench for the weight sorter.
module tb_sorter;

    logic [11:0] in;
    logic        clk;
    logic        reset;
    logic [7:0]  grp1, grp2, grp3, grp4, grp5, grp6;
    logic [2:0]  currgrp;

    int unsigned checks;
    int unsigned errors;

    sorter dut (
        .in      (in),
        .clk     (clk),
        .reset   (reset),
        .grp1    (grp1),
        .grp2    (grp2),
        .grp3    (grp3),
        .grp4    (grp4),
        .grp5    (grp5),
        .grp6    (grp6),
        .currgrp (currgrp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag,
                             input int unsigned e1, input int unsigned e2,
                             input int unsigned e3, input int unsigned e4,
                             input int unsigned e5, input int unsigned e6,
                             input int unsigned ecur);
        check({tag, ".grp1"}, grp1, e1);
        check({tag, ".grp2"}, grp2, e2);
        check({tag, ".grp3"}, grp3, e3);
        check({tag, ".grp4"}, grp4, e4);
        check({tag, ".grp5"}, grp5, e5);
        check({tag, ".grp6"}, grp6, e6);
        check({tag, ".currgrp"}, currgrp, ecur);
    endtask

    // Hold a weight for n rising edges, then settle 1 time unit past the edge.
    task automatic apply(input int unsigned w, input int unsigned n);
        in = 12'(w);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full reset cycle ending with reset released and in = 0.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        in    = 12'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    int unsigned bvals [12] = '{1, 250, 251, 500, 501, 750, 751, 1500, 1501, 2000, 2001, 4095};
    int unsigned bexp  [12] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6};
    int unsigned svals [7]  = '{250, 0, 300, 0, 501, 512, 2001};
    int unsigned sexp  [7]  = '{1, 0, 2, 0, 3, 3, 6};

    initial begin
        checks = 0;
        errors = 0;
        in     = 12'd1234;
        reset  = 1'b0;

        // reset: outputs clear and in ignored while asserted
        #2;
        check_all("reset.async", 0, 0, 0, 0, 0, 0, 0);
        apply(3000, 3);
        check_all("reset.held", 0, 0, 0, 0, 0, 0, 0);
        in    = 12'd0;
        reset = 1'b1;
        apply(0, 3);
        check_all("reset.release", 0, 0, 0, 0, 0, 0, 0);

        // sequence
        for (int i = 0; i < 7; i++) begin
            apply(svals[i], 2);
            check($sformatf("seq.cur%0d", i), currgrp, sexp[i]);
        end
        check_all("seq.final", 1, 1, 1, 0, 0, 0, 6);
        #2;
        reset = 1'b0;
        #1;
        check_all("seq.reset", 0, 0, 0, 0, 0, 0, 0);
        in = 12'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        apply(0, 2);
        check_all("seq.after", 0, 0, 0, 0, 0, 0, 0);

        // boundaries
        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply(bvals[i], 2);
            check($sformatf("bnd.w%0d", bvals[i]), currgrp, bexp[i]);
            apply(0, 2);
        end
        check_all("bnd.final", 2, 2, 2, 2, 2, 2, 0);

        // hold: constant weight counts nothing until it leaves
        do_reset();
        apply(800, 20);
        check_all("hold.on", 0, 0, 0, 0, 0, 0, 4);
        apply(0, 1);
        check_all("hold.leave", 0, 0, 0, 1, 0, 0, 0);
        apply(0, 3);
        check("hold.once", grp4, 1);

        // saturation
        do_reset();
        for (int i = 0; i < 255; i++) begin
            apply(100, 1);
            apply(0, 1);
        end
        check("sat.at255", grp1, 255);
        for (int i = 0; i < 5; i++) begin
            apply(100, 1);
            apply(0, 1);
        end
        check_all("sat.final", 255, 0, 0, 0, 0, 0, 0);

        // async reset mid-cycle with an item on the scale
        do_reset();
        apply(600, 2);
        check("areset.pre", currgrp, 3);
        #2;
        reset = 1'b0;
        #1;
        check_all("areset.clear", 0, 0, 0, 0, 0, 0, 0);
        in = 12'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        apply(0, 3);
        check_all("areset.after", 0, 0, 0, 0, 0, 0, 0);

        // direct nonzero-to-nonzero change counts old class once
        do_reset();
        apply(1600, 2);
        apply(100, 2);
        check_all("direct.switch", 0, 0, 0, 0, 1, 0, 1);
        apply(0, 1);
        check_all("direct.end", 1, 0, 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
